// File: rtl/video_pkg.sv
// Shared types and constants for the character-mode video generator.
package video_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      VRAM_RD = 2'd1,
      CG_RD   = 2'd2,
      DONE    = 2'd3
   } fetch_state_t;

   localparam int   PIXELS_PER_CHAR_DEF = 8;
   localparam logic MEM_SEL_VRAM        = 1'b0;
   localparam logic MEM_SEL_CG          = 1'b1;

endpackage

// File: rtl/video_shifter.sv
// Pixel shift register: parallel load of one glyph row, MSB-first shift-out,
// optional inversion (rvs) and blanking by display enable.
module video_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_load_rvs,
   input  logic             i_de,
   output logic             o_video
);

   logic [WIDTH-1:0] r_shift;
   logic             r_rvs;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
         r_rvs   <= 1'b0;
      end else if (i_load) begin
         r_shift <= i_load_data;
         r_rvs   <= i_load_rvs;
      end else if (i_shift) begin
         r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end
   end

   assign o_video = i_de & (r_shift[WIDTH-1] ^ r_rvs);

endmodule

// File: rtl/video_char_gen.sv
// Character generator: per character clock fetches the screen code from VRAM and the
// glyph row from the chargen over a req/ack bus, then drives the pixel shifter.
module video_char_gen
   import video_pkg::*;
#(
   parameter int PIXELS_PER_CHAR = PIXELS_PER_CHAR_DEF,
   parameter int VRAM_ADDR_WIDTH = 11,
   parameter int CG_ADDR_WIDTH   = 11
) (
   input  logic                     sys_clock_i,
   input  logic                     reset_ni,
   input  logic                     cclk_en_i,
   input  logic                     pix_en_i,
   input  logic [13:0]              ma_i,
   input  logic [4:0]               ra_i,
   input  logic                     de_i,
   input  logic                     h_sync_i,
   input  logic                     v_sync_i,
   input  logic                     gfx_i,
   output logic                     mem_req_o,
   output logic                     mem_sel_o,
   output logic [CG_ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [7:0]               mem_data_i,
   input  logic                     mem_ack_i,
   output logic                     video_o,
   output logic                     h_sync_o,
   output logic                     v_sync_o,
   output logic                     de_o,
   output logic                     underrun_o
);

   fetch_state_t r_state, w_state_next;
   logic         r_abort, w_abort_next;
   logic         r_req, w_req_next;
   logic         r_sel, w_sel_next;
   logic [CG_ADDR_WIDTH-1:0] r_addr, w_addr_next;
   logic         w_code_load, w_pat_load, w_pat_clear;

   logic         r_ta12_q, r_de_q, r_hs_q, r_vs_q, r_gfx_q;
   logic [4:0]   r_ra_q;
   logic         r_code_msb;
   logic [PIXELS_PER_CHAR-1:0] r_pattern;
   logic         r_de_o, r_hs_o, r_vs_o, r_underrun;

   logic [CG_ADDR_WIDTH-1:0]   w_vram_addr, w_cg_addr;
   logic                       w_busy, w_in_done, w_load_rvs;
   logic [PIXELS_PER_CHAR-1:0] w_load_data;
   logic                       w_unused_ma;

   assign w_unused_ma = ^{ma_i[13], ma_i[11]};
   assign w_busy      = (r_state == VRAM_RD) || (r_state == CG_RD);
   assign w_in_done   = (r_state == DONE);

   // The VRAM address comes from the live MA because it is captured on the same edge.
   always_comb begin
      w_vram_addr = '0;
      w_vram_addr[VRAM_ADDR_WIDTH-1:0] = ma_i[VRAM_ADDR_WIDTH-1:0];
      w_cg_addr = '0;
      w_cg_addr[10:0] = {r_gfx_q, mem_data_i[6:0], r_ra_q[2:0]};
   end

   always_ff @(posedge sys_clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= IDLE;
         r_abort <= 1'b0;
         r_req   <= 1'b0;
         r_sel   <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_next;
         r_abort <= w_abort_next;
         r_req   <= w_req_next;
         r_sel   <= w_sel_next;
         r_addr  <= w_addr_next;
      end
   end

   // A missed deadline marks the fetch aborted; it still runs to its ack, then idles.
   always_comb begin
      w_state_next = r_state;
      w_abort_next = r_abort;
      w_req_next   = r_req;
      w_sel_next   = r_sel;
      w_addr_next  = r_addr;
      w_code_load  = 1'b0;
      w_pat_load   = 1'b0;
      w_pat_clear  = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (cclk_en_i) begin
               w_state_next = VRAM_RD;
               w_req_next   = 1'b1;
               w_sel_next   = MEM_SEL_VRAM;
               w_addr_next  = w_vram_addr;
            end
         end
         VRAM_RD: begin
            if (cclk_en_i) w_abort_next = 1'b1;
            if (mem_ack_i) begin
               w_req_next = 1'b0;
               if (r_abort || cclk_en_i) begin
                  w_state_next = IDLE;
                  w_abort_next = 1'b0;
               end else begin
                  w_code_load = 1'b1;
                  if (r_ra_q[4:3] != 2'b00) begin
                     w_pat_clear  = 1'b1;
                     w_state_next = DONE;
                  end else begin
                     w_state_next = CG_RD;
                     w_req_next   = 1'b1;
                     w_sel_next   = MEM_SEL_CG;
                     w_addr_next  = w_cg_addr;
                  end
               end
            end
         end
         CG_RD: begin
            if (cclk_en_i) w_abort_next = 1'b1;
            if (mem_ack_i) begin
               w_req_next = 1'b0;
               if (r_abort || cclk_en_i) begin
                  w_state_next = IDLE;
                  w_abort_next = 1'b0;
               end else begin
                  w_pat_load   = 1'b1;
                  w_state_next = DONE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Stage-1 capture and stage-2 output advance share the cclk edge; stage-2 reads old stage-1.
   always_ff @(posedge sys_clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_ta12_q   <= 1'b0;
         r_ra_q     <= '0;
         r_de_q     <= 1'b0;
         r_hs_q     <= 1'b0;
         r_vs_q     <= 1'b0;
         r_gfx_q    <= 1'b0;
         r_code_msb <= 1'b0;
         r_pattern  <= '0;
         r_de_o     <= 1'b0;
         r_hs_o     <= 1'b0;
         r_vs_o     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (cclk_en_i) begin
            r_ta12_q <= ma_i[12];
            r_ra_q   <= ra_i;
            r_de_q   <= de_i;
            r_hs_q   <= h_sync_i;
            r_vs_q   <= v_sync_i;
            r_gfx_q  <= gfx_i;
            r_de_o   <= r_de_q;
            r_hs_o   <= r_hs_q;
            r_vs_o   <= r_vs_q;
            if (w_busy) r_underrun <= 1'b1;
         end
         if (w_code_load) r_code_msb <= mem_data_i[7];
         if (w_pat_load) begin
            r_pattern <= mem_data_i[PIXELS_PER_CHAR-1:0];
         end else if (w_pat_clear) begin
            r_pattern <= '0;
         end
      end
   end

   // Anything other than a finished fetch loads a blank, non-inverted row.
   assign w_load_data = w_in_done ? r_pattern : '0;
   assign w_load_rvs  = w_in_done & (r_code_msb ^ ~r_ta12_q);

   video_shifter #(.WIDTH(PIXELS_PER_CHAR)) u_shifter (
      .i_clk       (sys_clock_i),
      .i_rst_n     (reset_ni),
      .i_load      (cclk_en_i),
      .i_shift     (pix_en_i & ~cclk_en_i),
      .i_load_data (w_load_data),
      .i_load_rvs  (w_load_rvs),
      .i_de        (r_de_o),
      .o_video     (video_o)
   );

   assign mem_req_o  = r_req;
   assign mem_sel_o  = r_sel;
   assign mem_addr_o = r_addr;
   assign de_o       = r_de_o;
   assign h_sync_o   = r_hs_o;
   assign v_sync_o   = r_vs_o;
   assign underrun_o = r_underrun;

endmodule
